// File: rtl/cycle_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/MEM/WB with phase skipping, memory wait states and a watchdog.
// Optional build macro CYCLE_SEQUENCER_SKIP_COUNT_EN adds the annulled-instruction counter output 'skipped'.
module cycle_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               execute_flag,
    input  logic               is_mem_op,
    input  logic               is_load,
    input  logic               wb_needed,
    input  logic               mem_ready,
    output logic               instruction_en,
    output logic               read_en,
    output logic               ldr_str_en,
    output logic               write_en,
    output logic               pc_en,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired,
`ifdef CYCLE_SEQUENCER_SKIP_COUNT_EN
    output logic [COUNT_W-1:0] skipped,
`endif
    output logic               bus_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [2:0]         w_after_retire;
    logic [7:0]         r_wait;
    logic [7:0]         w_wait_inc;
    logic [COUNT_W-1:0] r_retired;
    logic               r_bus_error;
    logic               w_retire;
    logic               w_annul;
    logic               w_waiting;
    logic               w_timeout;

    assign w_wait_inc     = r_wait + 8'd1;
    assign w_waiting      = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    // The timeout fires on the MAX_WAIT-th consecutive waiting cycle; mem_ready in that cycle still wins.
    assign w_timeout      = w_waiting && (w_wait_inc == WAIT_LIMIT);
    assign w_after_retire = run ? S_FETCH : S_IDLE;

    // Next-state selection and retire/annul detection
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_annul  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (!execute_flag) begin
                    w_retire = 1'b1;
                    w_annul  = 1'b1;
                    w_next   = w_after_retire;
                end else if (is_mem_op) begin
                    w_next = S_MEM;
                end else if (wb_needed) begin
                    w_next = S_WB;
                end else begin
                    w_retire = 1'b1;
                    w_next   = w_after_retire;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = w_after_retire;
                    end
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = w_after_retire;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, wait counter, retire counter and sticky bus error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait      <= 8'd0;
            r_retired   <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_waiting && (w_next == r_state)) begin
                r_wait <= w_wait_inc;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_retire) begin
                r_retired <= r_retired + COUNT_W'(1);
            end else begin
                r_retired <= r_retired;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end else begin
                r_bus_error <= r_bus_error;
            end
        end
    end

`ifdef CYCLE_SEQUENCER_SKIP_COUNT_EN
    logic [COUNT_W-1:0] r_skipped;

    // Annulled-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skipped <= '0;
        end else if (w_annul) begin
            r_skipped <= r_skipped + COUNT_W'(1);
        end else begin
            r_skipped <= r_skipped;
        end
    end

    assign skipped = r_skipped;
`else
    logic w_annul_unused;
    assign w_annul_unused = w_annul;
`endif

    assign state          = r_state;
    assign instruction_en = (r_state == S_FETCH);
    assign read_en        = (r_state == S_DECODE);
    assign ldr_str_en     = (r_state == S_MEM);
    assign write_en       = (r_state == S_WB);
    assign pc_en          = w_retire;
    assign retired        = r_retired;
    assign bus_error      = r_bus_error;

endmodule
